// File: rtl/avalon_led_pio_blink.sv
// avalon_led_pio_blink
//   Avalon-MM slave output PIO for one board LED bank. Provides a DATA
//   register with readback and atomic set/clear/toggle aliases, per-bit
//   blink enables, and a programmable prescaler that generates the blink
//   phase.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous, active-low reset
//   address     register word address (0..7)
//   chipselect  slave select, qualifies write_n / read_n
//   write_n     active-low write strobe
//   read_n      active-low read strobe
//   writedata   write data (bits above a register's width are ignored)
//   readdata    registered read data, latency 1, zero-extended
//   out_port    LED drive, combinational from registers
module avalon_led_pio_blink #(
  parameter int unsigned             WIDTH        = 18,
  parameter logic [WIDTH-1:0]        RESET_VALUE  = '0,
  parameter int unsigned             PRESCALE_W   = 26,
  parameter int unsigned             PERIOD_RESET = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [PRESCALE_W-1:0] PERIOD_INIT = PRESCALE_W'(PERIOD_RESET);

  logic                  wr;
  logic                  rd;
  logic [WIDTH-1:0]      wd;
  logic [PRESCALE_W-1:0] wd_period;
  logic                  period_wr;

  logic [WIDTH-1:0]      data;
  logic [WIDTH-1:0]      blink_en;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] cnt;
  logic                  phase;
  logic [31:0]           rvalue;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & ~read_n;
  assign wd        = writedata[WIDTH-1:0];
  assign wd_period = writedata[PRESCALE_W-1:0];
  assign period_wr = wr && (address == 3'd5);

  // Register file: DATA with atomic aliases, blink enables, period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      period   <= PERIOD_INIT;
    end else if (wr) begin
      case (address)
        3'd0:    data     <= wd;
        3'd1:    data     <= data | wd;
        3'd2:    data     <= data & ~wd;
        3'd3:    data     <= data ^ wd;
        3'd4:    blink_en <= wd;
        3'd5:    period   <= wd_period;
        default: ;
      endcase
    end
  end

  // Prescaler. A PERIOD write overrides the terminal-count reload so the
  // new period always starts cleanly in phase 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= PERIOD_INIT;
      phase <= 1'b0;
    end else if (period_wr) begin
      cnt   <= wd_period;
      phase <= 1'b0;
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - PRESCALE_W'(1);
    end
  end

  // Read mux sees pre-write register values, so a simultaneous write and
  // read on the same address returns the old contents.
  always_comb begin
    rvalue = '0;
    case (address)
      3'd0, 3'd1, 3'd2, 3'd3: rvalue[WIDTH-1:0]      = data;
      3'd4:                   rvalue[WIDTH-1:0]      = blink_en;
      3'd5:                   rvalue[PRESCALE_W-1:0] = period;
      3'd6:                   rvalue[0]              = phase;
      default:                rvalue                 = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (rd) begin
      readdata <= rvalue;
    end
  end

  assign out_port = data & ~(blink_en & {WIDTH{phase}});

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// tb_avalon_led_pio_blink
//   Directed self-checking bench for avalon_led_pio_blink with WIDTH=18,
//   RESET_VALUE=18'h155 and a short PERIOD_RESET so reset-time counting is
//   observable. Inputs change on the falling edge; outputs are sampled on
//   the falling edge.
module tb_avalon_led_pio_blink;

  localparam int unsigned W  = 18;
  localparam int unsigned PR = 7;

  logic          clk;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic          read_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int checks;
  int errors;

  avalon_led_pio_blink #(
    .WIDTH        (W),
    .RESET_VALUE  (18'h155),
    .PRESCALE_W   (26),
    .PERIOD_RESET (PR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All bus tasks are entered on a falling edge and return on the next one.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic bus_write_read(input logic [2:0] a, input logic [31:0] wdv,
                                output logic [31:0] d);
    address = a; writedata = wdv; chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] exp);
    checks++;
    if (out_port !== exp) begin
      errors++;
      $display("FAIL %s: out_port=%h expected=%h", name, out_port, exp);
    end
  endtask

  task automatic chk_rd(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: readdata=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    apply_reset();
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata: readdata=%h expected=%h", readdata, 32'h0);
    end
    chk_out("reset_out", 18'h155);
    bus_read(3'd0, r); chk_rd("reset_data", r, 32'h155);
    bus_read(3'd6, r); chk_rd("reset_status", r, 32'h0);
    bus_read(3'd4, r); chk_rd("reset_blink_en", r, 32'h0);
    bus_read(3'd5, r); chk_rd("reset_period", r, PR);
  endtask

  task automatic test_data_ops();
    logic [31:0] r;
    bus_write(3'd0, 32'hFFFF_FFFF); chk_out("data_write", 18'h3FFFF);
    bus_write(3'd2, 32'h0000_000F); chk_out("data_clr",   18'h3FFF0);
    bus_write(3'd1, 32'h0001_0000); chk_out("data_set",   18'h3FFF0);
    bus_write(3'd3, 32'h0000_0003); chk_out("data_tog",   18'h3FFF3);
    bus_read(3'd0, r); chk_rd("data_zext", r, 32'h0003_FFF3);
    bus_read(3'd2, r); chk_rd("data_alias_clr", r, 32'h0003_FFF3);
    repeat (2) @(negedge clk);
    chk_rd("readdata_hold", readdata, 32'h0003_FFF3);
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    chk_out("ignored_writes", 18'h3FFF3);
    bus_read(3'd7, r); chk_rd("addr7_zero", r, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    bus_write_read(3'd0, 32'h0000_1234, r);
    chk_rd("rw_same_cycle_old", r, 32'h0003_FFF3);
    chk_out("rw_same_cycle_new", 18'h01234);
    bus_write_read(3'd1, 32'h0000_0001, r);
    chk_rd("rw_set_old", r, 32'h0000_1234);
    bus_read(3'd0, r); chk_rd("rw_set_new", r, 32'h0000_1235);
  endtask

  task automatic test_blink();
    logic [W-1:0] exp;
    bus_write(3'd0, 32'h3);
    bus_write(3'd4, 32'h1);
    bus_write(3'd5, 32'h3);
    // Phase 0 lasts 4 cycles from the PERIOD write, then phase 1 for 4.
    for (int k = 0; k < 16; k++) begin
      exp = (((k / 4) % 2) == 1) ? 18'h2 : 18'h3;
      chk_out($sformatf("blink_k%0d", k), exp);
      @(negedge clk);
    end
  endtask

  task automatic test_period_priority();
    bus_write(3'd5, 32'h5);
    // Counter is 5 after the write; it reaches 0 five edges later.
    repeat (5) @(negedge clk);
    chk_out("prio_before", 18'h3);
    bus_write(3'd5, 32'h2);
    chk_out("prio_no_toggle", 18'h3);
    @(negedge clk); chk_out("prio_cnt1", 18'h3);
    @(negedge clk); chk_out("prio_cnt0", 18'h3);
    @(negedge clk); chk_out("prio_toggle", 18'h2);
  endtask

  task automatic test_period_zero();
    logic [31:0] r;
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'h0002_AAAA);
    bus_write(3'd5, 32'h0);
    for (int k = 0; k < 10; k++) begin
      chk_out($sformatf("pzero_k%0d", k), 18'h2AAAA);
      @(negedge clk);
    end
    bus_read(3'd6, r); chk_rd("pzero_status", r, 32'h0);
    bus_read(3'd5, r); chk_rd("pzero_period", r, 32'h0);
    bus_read(3'd4, r); chk_rd("pzero_blink_en", r, 32'h0003_FFFF);
  endtask

  task automatic test_reset_mid_phase();
    logic [31:0] r;
    bus_write(3'd0, 32'h3FFFF);
    bus_write(3'd5, 32'h3);
    repeat (4) @(negedge clk);
    chk_out("mid_phase1", 18'h0);
    bus_read(3'd6, r); chk_rd("mid_status1", r, 32'h1);
    reset_n = 1'b0;
    #1;
    chk_out("async_reset_out", 18'h155);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd4, r); chk_rd("mid_rst_blink_en", r, 32'h0);
    bus_read(3'd5, r); chk_rd("mid_rst_period", r, PR);
    bus_read(3'd0, r); chk_rd("mid_rst_data", r, 32'h155);
  endtask

  task automatic test_reset_count();
    apply_reset();
    // cnt starts at PR=7: phase stays 0 for 8 edges after release.
    bus_write(3'd4, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      chk_out($sformatf("rst_cnt_k%0d", k), (k >= 8) ? 18'h154 : 18'h155);
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    address = '0;
    chipselect = 1'b0;
    write_n = 1'b1;
    read_n = 1'b1;
    writedata = '0;
    @(negedge clk);
    test_reset();
    test_data_ops();
    test_back_to_back();
    test_blink();
    test_period_priority();
    test_period_zero();
    test_reset_mid_phase();
    test_reset_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
